// File: rtl/riscv_pkg.sv
// riscv_pkg: constants shared by the RISC-V front-end pipeline blocks.
package riscv_pkg;
    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
endpackage

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem: DEPTH x (3*XLEN) entry storage, one write port and an asynchronous read port.
module if_id_queue_mem #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [3*XLEN-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [3*XLEN-1:0] rdata
);
    logic [3*XLEN-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: IF->ID instruction queue with flush; define IF_ID_BYPASS_EN to let an
// entry arriving at an empty queue reach ID in the same cycle.
module if_id_queue
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_instr,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [XLEN-1:0]        in_pc4,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_instr,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_pc4,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              empty, push, pop, store, pop_mem;
    logic [3*XLEN-1:0] head;

    always_comb begin
        empty = count_q == '0;
        in_ready = count_q < CW'(DEPTH);
        push = in_valid & in_ready & ~flush;
`ifdef IF_ID_BYPASS_EN
        // An empty queue forwards the incoming entry; if ID takes it, it is never stored.
        out_valid = ~flush & (~empty | (in_valid & ~rst));
        pop = out_valid & out_ready;
        store = push & ~(empty & out_ready);
        {out_instr, out_pc, out_pc4} = !empty ? head :
                                       (in_valid & ~flush & ~rst) ? {in_instr, in_pc, in_pc4} :
                                       {XLEN'(NOP_INSTR), {2*XLEN{1'b0}}};
`else
        out_valid = ~flush & ~empty;
        pop = out_valid & out_ready;
        store = push;
        {out_instr, out_pc, out_pc4} = empty ? {XLEN'(NOP_INSTR), {2*XLEN{1'b0}}} : head;
`endif
        pop_mem = pop & ~empty;
        wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(store);
        rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop_mem);
        count_d = flush ? '0 : count_q + CW'(store) - CW'(pop_mem);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

    if_id_queue_mem #(.XLEN(XLEN), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (store),
        .waddr (wr_ptr_q),
        .wdata ({in_instr, in_pc, in_pc4}),
        .raddr (rd_ptr_q),
        .rdata (head)
    );
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed scenarios plus random traffic against a queue-based model.
module tb_if_id_queue;
    import riscv_pkg::*;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
`ifdef IF_ID_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, out_ready, in_ready, out_valid;
    logic [XLEN-1:0] in_instr, in_pc, in_pc4, out_instr, out_pc, out_pc4;
    logic [1:0]      count;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } entry_t;

    entry_t q[$];
    int n_chk = 0;
    int n_pass = 0;

    if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_pc4    (in_pc4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_pc4   (out_pc4),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(bit r, bit f, bit v, logic [31:0] ins, logic [31:0] pc, bit ordy);
        @(negedge clk);
        rst = r;
        flush = f;
        in_valid = v;
        in_instr = ins;
        in_pc = pc;
        in_pc4 = pc + 32'd4;
        out_ready = ordy;
    endtask

    // Model: the queue contents as a plain list of entries, oldest first.
    always @(posedge clk or posedge rst) begin : mdl
        bit byp, full, pop;
        if (rst || flush) q.delete();
        else begin
            byp = BYP && in_valid && q.size() == 0;
            full = q.size() >= DEPTH;
            pop = q.size() != 0 && out_ready;
            if (!(byp && out_ready)) begin
                if (pop) void'(q.pop_front());
                if (in_valid && !full) q.push_back('{in_instr, in_pc, in_pc4});
            end
        end
    end

    always @(negedge clk) begin : cmp
        entry_t e;
        bit byp, ev;
        #2;
        byp = BYP && !rst && !flush && in_valid && q.size() == 0;
        ev = !flush && (q.size() != 0 || byp);
        if (q.size() != 0) e = q[0];
        else if (byp) e = '{in_instr, in_pc, in_pc4};
        else e = '{NOP_INSTR, 32'd0, 32'd0};
        chk("out_valid", out_valid, ev);
        chk("count", count, q.size());
        chk("count_max", count <= DEPTH, 1);
        chk("in_ready", in_ready, q.size() < DEPTH);
        chk("out_instr", out_instr, e.instr);
        chk("out_pc", out_pc, e.pc);
        chk("out_pc4", out_pc4, e.pc4);
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_instr = '0;
        in_pc = '0;
        in_pc4 = '0;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_instr", out_instr, 32'h0000_0013);
        chk("rst_ready", in_ready, 1);
        drive(0, 0, 1, 32'h0050_0093, 32'h0, 0);
        drive(0, 0, 1, 32'h00A0_0113, 32'h4, 0);
        drive(0, 0, 1, 32'h0000_0513, 32'h8, 1);
        #3;
        chk("fill_count", count, 2);
        chk("fill_ready", in_ready, 0);
        chk("fill_pc", out_pc, 32'h0);
        chk("fill_pc4", out_pc4, 32'h4);
        chk("fill_instr", out_instr, 32'h0050_0093);
        drive(0, 0, 0, 32'h0, 32'h0, 0);
        #3;
        chk("full_pp_count", count, 1);
        chk("full_pp_pc", out_pc, 32'h4);
        drive(0, 0, 1, 32'h0000_0013, 32'h10, 0);
        drive(0, 1, 1, 32'h0000_0013, 32'h8, 0);
        #3;
        chk("flush_valid", out_valid, 0);
        drive(0, 0, 0, 32'h0, 32'h0, 0);
        #3;
        chk("flush_count", count, 0);
        chk("flush_gone", out_valid, 0);
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 1, 32'h100 + i, 32'(4 * i), 1);
            #3;
`ifdef IF_ID_BYPASS_EN
            chk("wrap_pc", out_pc, 4 * i);
            chk("wrap_count", count, 0);
`else
            if (i > 0) begin
                chk("wrap_pc", out_pc, 4 * (i - 1));
                chk("wrap_count", count, 1);
            end
`endif
        end
        drive(0, 0, 0, 32'h0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 32'h0, 0);
        drive(0, 0, 1, 32'h0000_0033, 32'h20, 1);
        #3;
`ifdef IF_ID_BYPASS_EN
        chk("byp_valid", out_valid, 1);
        chk("byp_pc", out_pc, 32'h20);
`else
        chk("byp_valid", out_valid, 0);
`endif
        drive(0, 0, 0, 32'h0, 32'h0, 0);
        #3;
`ifdef IF_ID_BYPASS_EN
        chk("byp_count", count, 0);
`else
        chk("byp_count", count, 1);
        chk("byp_pc", out_pc, 32'h20);
`endif
        drive(0, 0, 0, 32'h0, 32'h0, 1);
        drive(0, 0, 1, 32'h0000_0093, 32'h40, 0);
        drive(0, 0, 1, 32'h0000_0113, 32'h44, 0);
        drive(1, 0, 0, 32'h0, 32'h0, 0);
        #3;
        chk("midrst_count", count, 0);
        chk("midrst_valid", out_valid, 0);
        drive(0, 0, 1, 32'h0000_0193, 32'h80, 0);
        drive(0, 0, 0, 32'h0, 32'h0, 0);
        #3;
        chk("midrst_push_count", count, 1);
        chk("midrst_push_pc", out_pc, 32'h80);
        repeat (3000)
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
                  $urandom, $urandom, $urandom_range(0, 3) != 0);
        @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the width of the instruction and PC fields.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the number of entries (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port flush, input, 1 bit: discard all queued and incoming entries (taken branch, jal or jalr from EX).
REQ-006 The block SHALL have port in_valid, input, 1 bit: the IF stage presents an entry.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the queue accepts an entry this cycle.
REQ-008 The block SHALL have ports in_instr, in_pc and in_pc4, inputs, XLEN bits each: instrCode, PC_IF and PC_4_IF from IF.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the head entry is valid for ID.
REQ-010 The block SHALL have port out_ready, input, 1 bit: ID consumes the head this cycle.
REQ-011 The block SHALL have ports out_instr, out_pc and out_pc4, outputs, XLEN bits each: the head entry fields.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: the current occupancy.

Function
REQ-013 The block SHALL perform a push when in_valid and in_ready are both 1 and flush is 0.
REQ-014 The block SHALL perform a pop when out_valid and out_ready are both 1 and flush is 0.
REQ-015 in_ready SHALL equal (count < DEPTH); it SHALL NOT depend on out_ready, so there is no push into a full queue even with a simultaneous pop.
REQ-016 On a simultaneous push and pop, count SHALL be unchanged, and both the read and write pointers SHALL advance.
REQ-017 The read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow below 0.
REQ-018 When the queue is not empty, out_valid SHALL be 1 and the out_* fields SHALL show the oldest entry. The data SHALL be stable until popped.
REQ-019 When the queue is empty, out_valid SHALL be 0 and out_instr SHALL be NOP (0x00000013), unless bypass applies (REQ-026).
REQ-020 Latency without bypass: an entry pushed at edge N SHALL be visible on out_* after edge N.
REQ-021 Flush SHALL take priority over push and pop. At the next edge, count SHALL be 0, the pointers SHALL be 0, and the same-cycle input SHALL be dropped.
REQ-022 On flush, out_valid SHALL be forced to 0 combinationally in the flush cycle.
REQ-023 Pop from an empty queue and push to a full queue SHALL be ignored, with no state change.

Reset
REQ-024 While rst=1, count SHALL be 0, the pointers SHALL be 0, out_valid SHALL be 0, out_instr SHALL be NOP, out_pc and out_pc4 SHALL be 0, and in_ready SHALL be 1.
REQ-025 Reset asserted mid-operation SHALL discard all entries immediately; the first push after rst deasserts SHALL behave as into an empty queue.

Configuration
REQ-026 With macro IF_ID_BYPASS_EN defined, when count=0, in_valid=1 and flush=0, the block SHALL drive out_valid=1 and pass in_* to out_* combinationally. If out_ready=1 in that cycle, the entry SHALL be consumed and not stored; otherwise it SHALL be stored as normal.
REQ-027 Without IF_ID_BYPASS_EN, there SHALL be no combinational path from in_* to out_*, and latency SHALL be exactly one cycle (REQ-020).

Structure
REQ-028 The constants XLEN_DEFAULT and NOP_INSTR (32'h00000013) SHALL reside in the shared package riscv_pkg.
REQ-029 Storage SHALL be one sub-module, if_id_queue_mem: a DEPTH x (3*XLEN) register array with one write port and an asynchronous read port. Pointer and count logic SHALL stay in the top.

Verification
REQ-030 Reset: rst=1 for 2 cycles -> count=0, out_valid=0, out_instr=0x00000013, in_ready=1.
REQ-031 Fill: push instr 0x00500093, PC 0x0 then 0x00A00113, PC 0x4 with out_ready=0 -> count=2, in_ready=0, and the head is PC 0x0 with pc4 0x4.
REQ-032 Full with simultaneous push/pop: with the queue full, in_valid=1 and out_ready=1 -> one pop, no push, count=1, and the head is PC 0x4.
REQ-033 Flush: with count=2, assert flush together with in_valid=1 (PC 0x8) -> out_valid=0 that cycle, count=0 next cycle, and the PC 0x8 entry is absent.
REQ-034 Wrap: 7 consecutive push/pop pairs with PCs 0x0 to 0x18 -> the output order matches the input order exactly and count never exceeds 2.
REQ-035 Bypass (IF_ID_BYPASS_EN): empty queue, in_valid=1, PC 0x20, out_ready=1 -> out_pc=0x20 in the same cycle and count stays 0. Without the macro, out_pc=0x20 appears one cycle later.
